riscv_seq_divider: RTL and testbench

Parametrised multi-cycle integer divider executing the four RISC-V M-extension divide operations: DIV, DIVU, REM and REMU. It is the execute-stage divide unit of the CPU. It accepts one operation per start pulse and returns a single selected result with a one-cycle done strobe. Divide-by-zero and signed-overflow cases are resolved by a fast path, bit-exact to the ISA.

---
 rtl/riscv_seq_divider.sv | 149 ++++++++++++++
 tb/tb_riscv_seq_divider.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_seq_divider.sv
// rtl/riscv_seq_divider.sv - multi-cycle RISC-V DIV/DIVU/REM/REMU unit
// Restoring divider, one quotient bit per cycle; zero divisor and signed overflow bypass the loop.
module riscv_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             sel_rem_q, sel_rem_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH+1:0] shifted, diff;
  logic [WIDTH-1:0] q_fix, r_fix;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & dividend[WIDTH-1];
    b_neg     = signed_op & divisor[WIDTH-1];
    // Negating the most-negative value wraps to itself, which read unsigned is its magnitude.
    a_mag     = a_neg ? -dividend : dividend;
    b_mag     = b_neg ? -divisor  : divisor;
    // The partial remainder stays below the divisor, so the extra top bit acts as the borrow.
    shifted   = {rem_q, quo_q[WIDTH-1]};
    diff      = shifted - {2'b00, dvsr_q};
    q_fix     = negq_q ? -quo_q : quo_q;
    r_fix     = negr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    sel_rem_d = sel_rem_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    result_d  = result_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sel_rem_d = op[1];
          negq_d    = a_neg ^ b_neg;
          negr_d    = a_neg;
          dvsr_d    = b_mag;
          quo_d     = a_mag;
          rem_d     = '0;
          cnt_d     = '0;
          if (divisor == '0) begin
            result_d = op[1] ? dividend : '1;
            dbz_d    = 1'b1;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else if (signed_op && dividend == MOST_NEG && divisor == '1) begin
            result_d = op[1] ? '0 : dividend;
            dbz_d    = 1'b0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (!diff[WIDTH+1]) begin
          rem_d = diff[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      default: begin
        result_d = sel_rem_q ? r_fix : q_fix;
        dbz_d    = 1'b0;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      sel_rem_q <= 1'b0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      result_q  <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      sel_rem_q <= sel_rem_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      result_q  <= result_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_riscv_seq_divider.sv
// tb/tb_riscv_seq_divider.sv - self-checking bench for riscv_seq_divider
module tb_riscv_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  riscv_seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: ISA semantics computed with 64-bit arithmetic.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic z, output int lat);
    longint sa, sb, q, m;
    z = (b == 32'd0);
    if (b == 32'd0) begin
      r   = o[1] ? a : 32'hFFFF_FFFF;
      lat = 1;
    end else begin
      if (!o[0]) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = {32'd0, a};
        sb = {32'd0, b};
      end
      q   = sa / sb;
      m   = sa % sb;
      r   = o[1] ? m[31:0] : q[31:0];
      lat = (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 1 : 34;
    end
  endfunction

  task automatic launch_now(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom_range(0, 3)); dividend = $urandom; divisor = $urandom;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    launch_now(o, a, b);
  endtask

  // Counts cycles after the accepting edge until done; returns -1 if done never comes.
  task automatic wait_done(input bit fast, input int inject, output int lat, output int busy_bad);
    lat = -1;
    busy_bad = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == inject) begin
        start = 1'b1; op = 2'b01; dividend = 32'd7; divisor = 32'd7;
      end else if (c == inject + 1) begin
        start = 1'b0;
      end
      if (done) begin
        lat = c;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== !fast) busy_bad++;
    end
  endtask

  initial begin
    logic [31:0] er;
    logic        ez;
    int          el, lat, bb, seen;
    logic [1:0]  o;
    logic [31:0] a, b;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0, 34};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0, 34};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 34};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 34};
    vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, 34};
    vecs[5]  = '{2'b00, 32'h8000_0001,  32'd1,          32'h8000_0001,  1'b0, 34};
    vecs[6]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 1};
    vecs[7]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1'b1, 1};
    vecs[8]  = '{2'b00, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1'b1, 1};
    vecs[9]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1};
    vecs[10] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1};
    vecs[11] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 34};
    vecs[12] = '{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b0, 34};

    rst = 1'b0; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    #3;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].lat == 1, 0, lat, bb);
      chk($sformatf("vec%0d result", i), result, vecs[i].res);
      chk($sformatf("vec%0d dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d busy errors", i), 32'(bb), 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d done pulse width", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d result held", i), result, vecs[i].res);
    end

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 20));
        4: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      ref_model(o, a, b, er, ez, el);
      launch(o, a, b);
      wait_done(el == 1, 0, lat, bb);
      chk($sformatf("rand%0d op%0d %h/%h result", i, o, a, b), result, er);
      chk($sformatf("rand%0d dbz", i), 32'(div_by_zero), 32'(ez));
      chk($sformatf("rand%0d latency", i), 32'(lat), 32'(el));
      chk($sformatf("rand%0d busy errors", i), 32'(bb), 32'd0);
    end

    launch(2'b01, 32'd1000, 32'd10);
    wait_done(1'b0, 10, lat, bb);
    chk("ignored start result", result, 32'd100);
    chk("ignored start latency", 32'(lat), 32'd34);
    chk("ignored start busy errors", 32'(bb), 32'd0);

    launch(2'b01, 32'd77, 32'd11);
    wait_done(1'b0, 0, lat, bb);
    chk("b2b first result", result, 32'd7);
    launch_now(2'b11, 32'd77, 32'd10);
    wait_done(1'b0, 0, lat, bb);
    chk("b2b second result", result, 32'd7);
    chk("b2b second latency", 32'(lat), 32'd34);
    chk("b2b busy errors", 32'(bb), 32'd0);

    launch(2'b01, 32'hDEAD_BEEF, 32'd3);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset done", 32'(done), 32'd0);
    chk("async reset result", result, 32'd0);
    chk("async reset dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("no done after reset", 32'(seen), 32'd0);

    launch(2'b01, 32'd9, 32'd3);
    wait_done(1'b0, 0, lat, bb);
    chk("post-reset result", result, 32'd3);
    chk("post-reset latency", 32'(lat), 32'd34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
